// File: rtl/sysid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sysid_pkg
// Description : Shared types and constants for the system-ID read master.
//               Contains the FSM state enum, the error codes reported on
//               error_code, the slave word addresses, and a helper that
//               ranks the two value comparisons.
// Revision    : 1.0 - initial release
// ============================================================================
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TS      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam int TIMER_WIDTH = 16;

    // An ID mismatch outranks a timestamp mismatch; timeouts are handled
    // by the FSM before this is ever consulted.
    function automatic logic [1:0] compare_code(
        input logic [31:0] id_word,
        input logic [31:0] ts_word,
        input logic [31:0] exp_id,
        input logic [31:0] exp_ts
    );
        if (id_word != exp_id) begin
            return ERR_ID;
        end
        if (ts_word != exp_ts) begin
            return ERR_TS;
        end
        return ERR_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysid_xact_timer.sv
`default_nettype none
// ============================================================================
// Module      : sysid_xact_timer
// Description : Per-transaction timeout counter. Counts cycles while enabled,
//               restarts from zero on clear, and flags the cycle in which the
//               count reaches TIMEOUT_CYCLES-1.
// Ports       : clk_i     - clock
//               rst_i     - synchronous active-high reset
//               clear_i   - load zero at the next edge (wins over enable)
//               enable_i  - advance the counter this cycle
//               expired_o - this enabled cycle is the last one allowed
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_xact_timer
    import sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMER_WIDTH-1:0] c_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/sysid_read_master.sv
`default_nettype none
// ============================================================================
// Module      : sysid_read_master
// Description : Avalon-MM read master that reads the system ID (word 0) and
//               the build timestamp (word 1) from a system-ID slave, compares
//               them with the expected build constants and reports the result.
// Ports       : clock, reset       - clock, synchronous active-high reset
//               start              - one-cycle pulse, starts a check when idle
//               address, read      - Avalon request (address held when idle)
//               waitrequest        - slave stall
//               readdata(32)       - slave read data
//               readdatavalid      - read data qualifier
//               busy, done         - sequence status / one-cycle end pulse
//               pass, error_code   - result, held until the next start
//               id_value(32)       - captured word 0, held
//               timestamp_value(32)- captured word 1, held
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_read_master
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1537796191,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  error_code,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value
);

    state_t      state_q;
    logic        read_q;
    logic        address_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [1:0]  error_code_q;
    logic [31:0] id_value_q;
    logic [31:0] timestamp_value_q;

    logic        w_accept;
    logic        w_id_complete;
    logic        w_timer_clear;
    logic        w_timer_enable;
    logic        w_expired;
    logic [1:0]  w_fin_code;

    // read_q is only ever high in the *_REQ states, so this is the Avalon
    // acceptance condition for the outstanding request.
    assign w_accept = read_q && !waitrequest;

    assign w_id_complete = ((state_q == ID_REQ) && w_accept && readdatavalid) ||
                           ((state_q == ID_WAIT) && readdatavalid);

    // The counter restarts on every entry into a request state.
    assign w_timer_clear  = ((state_q == IDLE) && start) || w_id_complete;
    assign w_timer_enable = (state_q == ID_REQ) || (state_q == ID_WAIT) ||
                            (state_q == TS_REQ) || (state_q == TS_WAIT);

    // Evaluated against the incoming timestamp so the verdict is registered
    // on the same edge the timestamp is captured, making pass/error_code
    // valid alongside done.
    assign w_fin_code = compare_code(id_value_q, readdata, EXPECTED_ID, EXPECTED_TIMESTAMP);

    sysid_xact_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clock),
        .rst_i     (reset),
        .clear_i   (w_timer_clear),
        .enable_i  (w_timer_enable),
        .expired_o (w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IDLE;
            read_q            <= 1'b0;
            address_q         <= ADDR_ID;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            error_code_q      <= ERR_NONE;
            id_value_q        <= '0;
            timestamp_value_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q           <= ID_REQ;
                        busy_q            <= 1'b1;
                        read_q            <= 1'b1;
                        address_q         <= ADDR_ID;
                        pass_q            <= 1'b0;
                        error_code_q      <= ERR_NONE;
                        id_value_q        <= '0;
                        timestamp_value_q <= '0;
                    end
                end

                ID_REQ: begin
                    if (w_accept && readdatavalid) begin
                        id_value_q <= readdata;
                        address_q  <= ADDR_TS;
                        state_q    <= TS_REQ;
                    end else if (w_expired) begin
                        // Acceptance without data at the limit is still
                        // an incomplete transaction.
                        read_q       <= 1'b0;
                        done_q       <= 1'b1;
                        error_code_q <= ERR_TIMEOUT;
                        pass_q       <= 1'b0;
                        state_q      <= FIN;
                    end else if (w_accept) begin
                        read_q  <= 1'b0;
                        state_q <= ID_WAIT;
                    end
                end

                ID_WAIT: begin
                    if (readdatavalid) begin
                        id_value_q <= readdata;
                        read_q     <= 1'b1;
                        address_q  <= ADDR_TS;
                        state_q    <= TS_REQ;
                    end else if (w_expired) begin
                        done_q       <= 1'b1;
                        error_code_q <= ERR_TIMEOUT;
                        pass_q       <= 1'b0;
                        state_q      <= FIN;
                    end
                end

                TS_REQ: begin
                    if (w_accept && readdatavalid) begin
                        timestamp_value_q <= readdata;
                        read_q            <= 1'b0;
                        done_q            <= 1'b1;
                        error_code_q      <= w_fin_code;
                        pass_q            <= (w_fin_code == ERR_NONE);
                        state_q           <= FIN;
                    end else if (w_expired) begin
                        read_q       <= 1'b0;
                        done_q       <= 1'b1;
                        error_code_q <= ERR_TIMEOUT;
                        pass_q       <= 1'b0;
                        state_q      <= FIN;
                    end else if (w_accept) begin
                        read_q  <= 1'b0;
                        state_q <= TS_WAIT;
                    end
                end

                TS_WAIT: begin
                    if (readdatavalid) begin
                        timestamp_value_q <= readdata;
                        done_q            <= 1'b1;
                        error_code_q      <= w_fin_code;
                        pass_q            <= (w_fin_code == ERR_NONE);
                        state_q           <= FIN;
                    end else if (w_expired) begin
                        done_q       <= 1'b1;
                        error_code_q <= ERR_TIMEOUT;
                        pass_q       <= 1'b0;
                        state_q      <= FIN;
                    end
                end

                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    read_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign address         = address_q;
    assign read            = read_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign error_code      = error_code_q;
    assign id_value        = id_value_q;
    assign timestamp_value = timestamp_value_q;

endmodule
`default_nettype wire

// File: tb/tb_sysid_read_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysid_read_master
// Description : Self-checking bench for sysid_read_master. A behavioural
//               Avalon slave with per-word stall/latency settings answers the
//               DUT; expected results come from a cycle-budget model of each
//               read sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_read_master;

    localparam logic [31:0] c_EXP_ID  = 32'd0;
    localparam logic [31:0] c_EXP_TS  = 32'd1537796191;
    localparam int          c_TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  error_code;
    logic [31:0] id_value;
    logic [31:0] timestamp_value;

    always #5 clock = ~clock;

    sysid_read_master #(
        .EXPECTED_ID        (c_EXP_ID),
        .EXPECTED_TIMESTAMP (c_EXP_TS),
        .TIMEOUT_CYCLES     (c_TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .address         (address),
        .read            (read),
        .waitrequest     (waitrequest),
        .readdata        (readdata),
        .readdatavalid   (readdatavalid),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .error_code      (error_code),
        .id_value        (id_value),
        .timestamp_value (timestamp_value)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave configuration per word address, and monitor counters.
    int          sl_wait [2];
    int          sl_dly  [2];
    logic [31:0] sl_data [2];
    int          rd_cycles [2];
    int          done_pulses;
    int          addr_glitch;

    // Behavioural slave: stalls sl_wait cycles, then accepts; data follows
    // sl_dly cycles after acceptance (0 = same cycle). Everything is driven
    // at the falling edge for the next rising edge.
    initial begin : slave
        int   stall_cnt;
        int   pend_cnt;
        logic pend_addr;
        logic prev_stall;
        logic prev_addr;
        waitrequest   = 1'b1;
        readdatavalid = 1'b0;
        readdata      = '0;
        stall_cnt     = 0;
        pend_cnt      = 0;
        pend_addr     = 1'b0;
        prev_stall    = 1'b0;
        prev_addr     = 1'b0;
        forever begin
            @(negedge clock);
            readdatavalid = 1'b0;
            readdata      = $urandom;
            if (done === 1'b1) done_pulses++;
            if (read === 1'b1) begin
                rd_cycles[address]++;
                if (prev_stall && (address !== prev_addr)) addr_glitch++;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    readdatavalid = 1'b1;
                    readdata      = sl_data[pend_addr];
                end
            end
            if (read === 1'b1) begin
                if (stall_cnt < sl_wait[address]) begin
                    waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    waitrequest = 1'b0;
                    stall_cnt   = 0;
                    if (sl_dly[address] == 0) begin
                        readdatavalid = 1'b1;
                        readdata      = sl_data[address];
                    end else begin
                        pend_cnt  = sl_dly[address];
                        pend_addr = address;
                    end
                end
            end else begin
                waitrequest = 1'b1;
                stall_cnt   = 0;
            end
            prev_stall = (read === 1'b1) && waitrequest;
            prev_addr  = address;
        end
    end

    // One check sequence. The model: a transaction of w stall cycles and
    // d data-latency cycles needs w+d+1 cycles and completes only when
    // w+d <= TIMEOUT-1; otherwise it lasts TIMEOUT cycles and aborts.
    task automatic run_seq(input int w0, input int d0, input int w1, input int d1,
                           input logic [31:0] data0, input logic [31:0] data1,
                           input bit restart, input string tag);
        bit          to0;
        bit          to1;
        int          dur0;
        int          dur1;
        int          e_rd0;
        int          e_rd1;
        int          e_done;
        logic [1:0]  e_err;
        logic [31:0] e_id;
        logic [31:0] e_ts;
        int          k;
        bit          seen;

        to0   = (w0 + d0) > (c_TIMEOUT - 1);
        dur0  = to0 ? c_TIMEOUT : (w0 + 1 + d0);
        e_rd0 = (w0 + 1 < c_TIMEOUT) ? (w0 + 1) : c_TIMEOUT;
        to1   = 1'b0;
        dur1  = 0;
        e_rd1 = 0;
        e_id  = '0;
        e_ts  = '0;
        if (to0) begin
            e_err = 2'd3;
        end else begin
            e_id  = data0;
            to1   = (w1 + d1) > (c_TIMEOUT - 1);
            dur1  = to1 ? c_TIMEOUT : (w1 + 1 + d1);
            e_rd1 = (w1 + 1 < c_TIMEOUT) ? (w1 + 1) : c_TIMEOUT;
            if (to1) begin
                e_err = 2'd3;
            end else begin
                e_ts  = data1;
                e_err = (data0 != c_EXP_ID) ? 2'd1 : ((data1 != c_EXP_TS) ? 2'd2 : 2'd0);
            end
        end
        e_done = 1 + dur0 + dur1;

        @(negedge clock);
        sl_wait[0] = w0;  sl_dly[0] = d0;  sl_data[0] = data0;
        sl_wait[1] = w1;  sl_dly[1] = d1;  sl_data[1] = data1;
        rd_cycles[0] = 0;
        rd_cycles[1] = 0;
        done_pulses  = 0;
        addr_glitch  = 0;
        start = 1'b1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 300) begin
            @(negedge clock);
            k++;
            start = (restart && k == 2) ? 1'b1 : 1'b0;
            if (k == 1) check_value($sformatf("%s.busy_rise", tag), 32'(busy), 32'd1);
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            check_value($sformatf("%s.done_seen", tag), 32'd0, 32'd1);
        end else begin
            check_value($sformatf("%s.done_cycle", tag), 32'(k), 32'(e_done));
            check_value($sformatf("%s.busy_at_done", tag), 32'(busy), 32'd1);
            check_value($sformatf("%s.pass", tag), 32'(pass), 32'(e_err == 2'd0));
            check_value($sformatf("%s.error_code", tag), 32'(error_code), 32'(e_err));
            check_value($sformatf("%s.id_value", tag), id_value, e_id);
            check_value($sformatf("%s.ts_value", tag), timestamp_value, e_ts);
            @(negedge clock);
            check_value($sformatf("%s.busy_fall", tag), 32'(busy), 32'd0);
            check_value($sformatf("%s.done_fall", tag), 32'(done), 32'd0);
        end
        repeat (10) @(negedge clock);
        check_value($sformatf("%s.rd_cycles0", tag), 32'(rd_cycles[0]), 32'(e_rd0));
        check_value($sformatf("%s.rd_cycles1", tag), 32'(rd_cycles[1]), 32'(e_rd1));
        check_value($sformatf("%s.done_pulses", tag), 32'(done_pulses), 32'd1);
        check_value($sformatf("%s.addr_stable", tag), 32'(addr_glitch), 32'd0);
        check_value($sformatf("%s.err_held", tag), 32'(error_code), 32'(e_err));
        check_value($sformatf("%s.ts_held", tag), timestamp_value, e_ts);
    endtask

    // Reset while waiting for the timestamp; the late data must be dropped.
    task automatic reset_mid_ts();
        int k;
        bit hit;
        @(negedge clock);
        sl_wait[0] = 0;  sl_dly[0] = 0;  sl_data[0] = 32'h0000_0005;
        sl_wait[1] = 0;  sl_dly[1] = 6;  sl_data[1] = c_EXP_TS;
        done_pulses = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k   = 0;
        hit = 1'b0;
        while (!hit && k < 50) begin
            if (busy === 1'b1 && read === 1'b0 && address === 1'b1) hit = 1'b1;
            else begin
                @(negedge clock);
                k++;
            end
        end
        check_value("rst_mid.reached_ts_wait", 32'(hit), 32'd1);
        check_value("rst_mid.id_before", id_value, 32'h0000_0005);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_value("rst_mid.read", 32'(read), 32'd0);
        check_value("rst_mid.busy", 32'(busy), 32'd0);
        check_value("rst_mid.id_value", id_value, 32'd0);
        check_value("rst_mid.error_code", 32'(error_code), 32'd0);
        repeat (10) @(negedge clock);
        check_value("rst_mid.late_ts", timestamp_value, 32'd0);
        check_value("rst_mid.late_busy", 32'(busy), 32'd0);
        check_value("rst_mid.late_pass", 32'(pass), 32'd0);
        check_value("rst_mid.no_done", 32'(done_pulses), 32'd0);
    endtask

    initial begin : main
        int w0;
        int d0;
        int w1;
        int d1;
        logic [31:0] v0;
        logic [31:0] v1;
        bit rs;

        sl_wait[0] = 0; sl_wait[1] = 0; sl_dly[0] = 0; sl_dly[1] = 0;
        sl_data[0] = c_EXP_ID; sl_data[1] = c_EXP_TS;
        rd_cycles[0] = 0; rd_cycles[1] = 0;
        done_pulses = 0; addr_glitch = 0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check_value("reset.read", 32'(read), 32'd0);
        check_value("reset.busy", 32'(busy), 32'd0);
        check_value("reset.done", 32'(done), 32'd0);
        check_value("reset.pass", 32'(pass), 32'd0);
        check_value("reset.error_code", 32'(error_code), 32'd0);
        check_value("reset.id_value", id_value, 32'd0);
        check_value("reset.ts_value", timestamp_value, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_seq(0, 0, 0, 0, c_EXP_ID, c_EXP_TS, 1'b0, "zero_wait");
        run_seq(5, 2, 5, 2, c_EXP_ID, c_EXP_TS, 1'b0, "stall");
        run_seq(0, 0, 0, 0, 32'h0000_0007, c_EXP_TS, 1'b0, "id_mismatch");
        run_seq(1000, 0, 0, 0, c_EXP_ID, c_EXP_TS, 1'b0, "stall_forever");
        run_seq(0, 0, 0, 0, c_EXP_ID, c_EXP_TS ^ 32'd1, 1'b0, "ts_mismatch");
        run_seq(2, 1, 3, 0, c_EXP_ID, c_EXP_TS, 1'b1, "restart_busy");
        run_seq(10, 5, 0, 0, c_EXP_ID, c_EXP_TS, 1'b0, "limit_complete");
        run_seq(10, 6, 0, 0, c_EXP_ID, c_EXP_TS, 1'b0, "limit_timeout");
        run_seq(15, 0, 0, 0, c_EXP_ID, c_EXP_TS, 1'b0, "accept_at_limit");
        run_seq(15, 1, 0, 0, c_EXP_ID, c_EXP_TS, 1'b0, "accept_at_limit_nodata");
        run_seq(0, 0, 9, 7, c_EXP_ID, c_EXP_TS, 1'b0, "ts_timeout");
        run_seq(0, 0, 20, 0, 32'h0000_0007, c_EXP_TS, 1'b0, "id_bad_ts_timeout");

        reset_mid_ts();
        run_seq(0, 0, 0, 0, c_EXP_ID, c_EXP_TS, 1'b0, "after_reset");

        for (int i = 0; i < 25; i++) begin
            w0 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 6));
            d0 = int'($urandom_range(0, 4));
            w1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 6));
            d1 = int'($urandom_range(0, 4));
            v0 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : c_EXP_ID;
            v1 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : c_EXP_TS;
            rs = ($urandom_range(0, 3) == 0);
            run_seq(w0, d0, w1, d1, v0, v1, rs, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sysid_read_master.md
Name: sysid_read_master

Overview:
- Avalon-MM read master that queries a system-ID control slave.
- Reads word 0 (system ID) and then word 1 (build timestamp), captures both values and compares them against the expected build constants.
- Reports pass/fail with an error code.
- Sits between the boot/debug controller and the interconnect, so hardware can refuse to run against a mismatched software image.

Parameters:
- EXPECTED_ID, 32'd0: expected readdata at word address 0.
- EXPECTED_TIMESTAMP, 32'd1537796191: expected readdata at word address 1.
- TIMEOUT_CYCLES, 255: max cycles per transaction (request plus data wait) before abort; range 1..65535.

Ports:
- clock  in  1  system clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a check sequence when idle.
- address  out  1  word address to the slave (0 = ID, 1 = timestamp).
- read  out  1  Avalon read request.
- waitrequest  in  1  slave stall; the request is accepted when read=1 and waitrequest=0.
- readdata  in  32  slave read data.
- readdatavalid  in  1  readdata qualifier; may coincide with the acceptance cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sequence ends.
- pass  out  1  1 when both values matched; held until the next start.
- error_code  out  2  0 ok, 1 ID mismatch, 2 timestamp mismatch, 3 timeout; held.
- id_value  out  32  captured ID word; held.
- timestamp_value  out  32  captured timestamp word; held.

Behaviour:
- Reset is synchronous: at a clock edge with reset=1 all outputs go to 0 and the FSM goes to IDLE. This holds mid-transaction too: read drops at that edge, and any late readdatavalid afterwards is ignored.
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN.
- IDLE:
  - start=1 -> ID_REQ. At that edge, clear pass, error_code, id_value, timestamp_value and the timeout counter; busy=1 next cycle.
  - start while not IDLE is ignored.
- ID_REQ:
  - Drive read=1, address=0. Both are held stable while waitrequest=1.
  - On acceptance:
    - if readdatavalid is also 1, capture id_value and go to TS_REQ;
    - otherwise go to ID_WAIT with read=0.
- ID_WAIT: read=0. On readdatavalid=1, capture id_value -> TS_REQ.
- TS_REQ / TS_WAIT: identical to ID_REQ / ID_WAIT with address=1, capturing timestamp_value; completion -> FIN.
- Timeout:
  - A 16-bit counter resets to 0 on entry to each *_REQ state and increments every cycle in REQ/WAIT.
  - When the counter equals TIMEOUT_CYCLES-1 and the transaction has not completed in that cycle -> FIN with error_code=3; read is deasserted at that edge.
  - Completion in the same cycle as the limit counts as completion, not timeout.
- Both reads are always performed unless a timeout occurs (a timeout in ID skips the TS read).
- Error priority: timeout(3) > ID mismatch(1) > TS mismatch(2).
  - Mismatches are evaluated in FIN against the captured registers.
  - pass = (error_code==0).
- FIN: lasts one cycle with done=1. At the transition to IDLE, busy=0 and pass/error_code are registered. done, pass and error_code are visible in the same cycle.
- Latency with a zero-wait slave and readdatavalid coinciding with acceptance: start at cycle 0 -> read at cycles 1 and 2 -> done at cycle 3.
- address holds its last value when read=0.

Decomposition:
- Shared package sysid_pkg holds:
  - the state enum;
  - error code constants ERR_NONE=0, ERR_ID=1, ERR_TS=2, ERR_TIMEOUT=3;
  - word address constants ADDR_ID=0, ADDR_TS=1.
- One natural sub-module: sysid_xact_timer, the 16-bit per-transaction timeout counter with clear/enable/expired. The FSM stays in the top level.

Test Plan:
- Zero-wait slave returning 0 / 1537796191, readdatavalid coinciding with acceptance, start at cycle 0 -> read at cycles 1-2, done at cycle 3, pass=1, error_code=0.
- waitrequest held 5 cycles on each read, readdatavalid 2 cycles after acceptance -> address stable during stall, both values captured, pass=1.
- Slave returns ID 32'h00000007 -> both reads still issued, error_code=1, pass=0, id_value=7.
- Slave never deasserts waitrequest, TIMEOUT_CYCLES=16 -> read high for exactly 16 cycles then low, done pulses, error_code=3, no address=1 read issued.
- reset asserted while in TS_WAIT, then a late readdatavalid -> read=0, busy=0, all outputs 0, late data not captured; a following start runs a clean pass.
- start pulsed again while busy -> ignored; exactly one done per accepted start.
